// File: rtl/cruise_regulator_if.sv
// rtl/cruise_regulator_if.sv - set-point / magnitude-comparator bus between regulator and comparator chain
interface cruise_regulator_if #(
   parameter int SPEED_W = 8
);
   logic [SPEED_W-1:0] SET_SPEED;
   logic               L;
   logic               EQ;
   logic               G;

   modport master (output SET_SPEED, input L, input EQ, input G);
   modport slave  (input SET_SPEED, output L, output EQ, output G);
endinterface

// File: rtl/cruise_regulator.sv
// rtl/cruise_regulator.sv - cruise mode FSM, set-point register and debounced throttle commands
module cruise_regulator #(
   parameter int SPEED_W   = 8,
   parameter int MIN_SPEED = 40,
   parameter int HOLD_CYC  = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                on_sw,
   input  logic                set_btn,
   input  logic                resume_btn,
   input  logic                brake,
   input  logic                accel,
   input  logic [SPEED_W-1:0]  speed,
   cruise_regulator_if.master  cmp,
   output logic                ACTIVE,
   output logic                THR_UP,
   output logic                THR_DN,
   output logic                CMP_ERR
);
   typedef enum logic [1:0] {S_OFF, S_STANDBY, S_ENGAGED, S_OVERRIDE} state_t;

   localparam logic [3:0] HOLD = 4'(HOLD_CYC);

   state_t             state, state_nx;
   logic [SPEED_W-1:0] set_speed, set_speed_nx;
   logic               valid, valid_nx, sp_wr;
   logic               set_q, resume_q;
   logic               set_edge, resume_edge, speed_ok;
   logic               engaged, onehot, fault, same_class;
   logic [3:0]         cnt;
   logic               cls_g;
   logic               thr_up_nx, thr_dn_nx;

   assign set_edge    = set_btn & ~set_q;
   assign resume_edge = resume_btn & ~resume_q;
   assign speed_ok    = speed >= SPEED_W'(MIN_SPEED);
   assign engaged     = (state == S_ENGAGED);
   // exactly one of three: odd parity and not all three high
   assign onehot      = (cmp.L ^ cmp.EQ ^ cmp.G) & ~(cmp.L & cmp.EQ & cmp.G);
   assign fault       = engaged & ~onehot;
   assign same_class  = (cnt != 4'd0) && (cls_g == cmp.G);
   assign cmp.SET_SPEED = set_speed;

   always_comb begin
      state_nx     = state;
      set_speed_nx = set_speed;
      valid_nx     = valid;
      sp_wr        = 1'b0;
      if (!on_sw) begin
         state_nx     = S_OFF;
         set_speed_nx = '0;
         valid_nx     = 1'b0;
      end else begin
         case (state)
            S_OFF: state_nx = S_STANDBY;
            S_STANDBY: begin
               if (!brake) begin
                  if (set_edge && speed_ok) begin
                     set_speed_nx = speed;
                     valid_nx     = 1'b1;
                     sp_wr        = 1'b1;
                     state_nx     = S_ENGAGED;
                  end else if (resume_edge && valid) begin
                     state_nx = S_ENGAGED;
                  end
               end
            end
            S_ENGAGED, S_OVERRIDE: begin
               if (brake) begin
                  state_nx = S_STANDBY;
               end else begin
                  if (set_edge && speed_ok) begin
                     set_speed_nx = speed;
                     valid_nx     = 1'b1;
                     sp_wr        = 1'b1;
                  end
                  state_nx = accel ? S_OVERRIDE : S_ENGAGED;
               end
            end
            default: state_nx = S_OFF;
         endcase
      end
   end

   // commands also require staying engaged, so they never outlive ACTIVE
   assign thr_up_nx = engaged && (state_nx == S_ENGAGED) && !sp_wr && !fault
                      && cmp.L && same_class && (cnt == HOLD);
   assign thr_dn_nx = engaged && (state_nx == S_ENGAGED) && !sp_wr && !fault
                      && cmp.G && same_class && (cnt == HOLD);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_OFF;
         set_speed <= '0;
         valid     <= 1'b0;
         set_q     <= 1'b0;
         resume_q  <= 1'b0;
         ACTIVE    <= 1'b0;
         THR_UP    <= 1'b0;
         THR_DN    <= 1'b0;
         CMP_ERR   <= 1'b0;
         cnt       <= 4'd0;
         cls_g     <= 1'b0;
      end else begin
         state     <= state_nx;
         set_speed <= set_speed_nx;
         valid     <= valid_nx;
         set_q     <= set_btn;
         resume_q  <= resume_btn;
         ACTIVE    <= (state_nx == S_ENGAGED);
         THR_UP    <= thr_up_nx;
         THR_DN    <= thr_dn_nx;
         if (!on_sw)
            CMP_ERR <= 1'b0;
         else if (fault)
            CMP_ERR <= 1'b1;
         if (!engaged || fault || cmp.EQ || sp_wr) begin
            cnt <= 4'd0;
         end else if (same_class) begin
            if (cnt != HOLD)
               cnt <= cnt + 4'd1;
         end else begin
            cnt   <= 4'd1;
            cls_g <= cmp.G;
         end
      end
   end
endmodule

// File: tb/tb_cruise_regulator.sv
// tb/tb_cruise_regulator.sv - randomized bench for cruise_regulator against a mode/streak reference model
module tb_cruise_regulator;
   localparam int HOLD = 3;
   localparam int MINS = 40;
   localparam int M_OFF = 0, M_STBY = 1, M_ENG = 2, M_OVR = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       on_sw = 1'b0, set_btn = 1'b0, resume_btn = 1'b0, brake = 1'b0, accel = 1'b0;
   logic [7:0] speed = 8'd0;
   logic       inj = 1'b0;
   logic       ACTIVE, THR_UP, THR_DN, CMP_ERR;

   int n_checks = 0;
   int n_errors = 0;

   int m_mode = M_OFF, m_sp = 0, m_streak = 0, m_cls = 0;
   bit m_valid = 0, m_pset = 0, m_pres = 0, m_up = 0, m_dn = 0, m_err = 0, m_act = 0;

   cruise_regulator_if #(.SPEED_W(8)) cmp ();

   cruise_regulator #(.SPEED_W(8), .MIN_SPEED(MINS), .HOLD_CYC(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .on_sw(on_sw), .set_btn(set_btn), .resume_btn(resume_btn),
      .brake(brake), .accel(accel), .speed(speed), .cmp(cmp),
      .ACTIVE(ACTIVE), .THR_UP(THR_UP), .THR_DN(THR_DN), .CMP_ERR(CMP_ERR)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit l, input bit e, input bit g);
      bit se, re, fault, eng, wrote;
      int nmode, cls_now;
      if (!rst_n) begin
         m_mode = M_OFF; m_sp = 0; m_valid = 0; m_pset = 0; m_pres = 0;
         m_streak = 0; m_cls = 0; m_up = 0; m_dn = 0; m_err = 0; m_act = 0;
         return;
      end
      se = set_btn && !m_pset;
      re = resume_btn && !m_pres;
      m_pset = set_btn;
      m_pres = resume_btn;
      fault = (int'(l) + int'(e) + int'(g)) != 1;
      eng = (m_mode == M_ENG);
      wrote = 0;
      nmode = m_mode;
      if (!on_sw) begin
         nmode = M_OFF; m_sp = 0; m_valid = 0;
      end else if (m_mode == M_OFF) begin
         nmode = M_STBY;
      end else if (brake && (m_mode == M_ENG || m_mode == M_OVR)) begin
         nmode = M_STBY;
      end else if (m_mode == M_STBY) begin
         if (!brake && se && speed >= MINS) begin
            m_sp = speed; m_valid = 1; wrote = 1; nmode = M_ENG;
         end else if (!brake && re && m_valid) begin
            nmode = M_ENG;
         end
      end else begin
         if (se && speed >= MINS) begin
            m_sp = speed; m_valid = 1; wrote = 1;
         end
         nmode = accel ? M_OVR : M_ENG;
      end
      if (!on_sw) m_err = 0;
      else if (eng && fault) m_err = 1;
      // streak = consecutive engaged cycles that saw the same clean L or G
      if (eng && !fault && !e && !wrote) begin
         cls_now = l ? 1 : 2;
         if (m_streak > 0 && m_cls == cls_now) m_streak = (m_streak < 100) ? m_streak + 1 : 100;
         else begin m_streak = 1; m_cls = cls_now; end
      end else begin
         m_streak = 0;
      end
      m_up = eng && nmode == M_ENG && !wrote && !fault && l && m_streak >= HOLD + 1;
      m_dn = eng && nmode == M_ENG && !wrote && !fault && g && m_streak >= HOLD + 1;
      m_mode = nmode;
      m_act = (nmode == M_ENG);
   endtask

   task automatic tick();
      bit l, e, g;
      logic [2:0] bad;
      l = speed < m_sp;
      e = speed == m_sp;
      g = speed > m_sp;
      if (inj) begin
         bad = 3'($urandom_range(0, 4));
         case (bad)
            3'd0: {l, e, g} = 3'b000;
            3'd1: {l, e, g} = 3'b011;
            3'd2: {l, e, g} = 3'b101;
            3'd3: {l, e, g} = 3'b110;
            default: {l, e, g} = 3'b111;
         endcase
      end
      cmp.L = l; cmp.EQ = e; cmp.G = g;
      model_step(l, e, g);
      @(posedge clk);
      #1;
      check("set_speed", int'(cmp.SET_SPEED), m_sp);
      check("active", int'(ACTIVE), int'(m_act));
      check("thr_up", int'(THR_UP), int'(m_up));
      check("thr_dn", int'(THR_DN), int'(m_dn));
      check("cmp_err", int'(CMP_ERR), int'(m_err));
   endtask

   task automatic pulse_set();
      set_btn = 1'b1; tick(); set_btn = 1'b0; tick();
   endtask

   task automatic pulse_resume();
      resume_btn = 1'b1; tick(); resume_btn = 1'b0; tick();
   endtask

   initial begin
      cmp.L = 1'b0; cmp.EQ = 1'b0; cmp.G = 1'b0;
      #1;
      rst_n = 1'b0;
      tick(); tick();
      check("rst_active", int'(ACTIVE), 0);
      check("rst_set_speed", int'(cmp.SET_SPEED), 0);
      rst_n = 1'b1;

      on_sw = 1'b1; speed = 8'd60;
      tick();
      pulse_set();
      check("engage_sp", int'(cmp.SET_SPEED), 60);
      check("engage_active", int'(ACTIVE), 1);
      speed = 8'd50;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("thr_up_latency", int'(THR_UP), (k == 4) ? 1 : 0);
      end
      speed = 8'd60;
      tick();
      check("thr_up_drop_eq", int'(THR_UP), 0);

      brake = 1'b1; tick();
      check("brake_standby", int'(ACTIVE), 0);
      check("brake_keeps_sp", int'(cmp.SET_SPEED), 60);
      brake = 1'b0;
      pulse_resume();
      check("resume_engaged", int'(ACTIVE), 1);

      speed = 8'd70; accel = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      check("override_no_dn", int'(THR_DN), 0);
      accel = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      check("dn_after_override", int'(THR_DN), 1);

      inj = 1'b1; tick(); inj = 1'b0;
      check("cmp_err_set", int'(CMP_ERR), 1);
      tick();
      check("cmp_err_sticky", int'(CMP_ERR), 1);

      on_sw = 1'b0; tick();
      check("off_clears_sp", int'(cmp.SET_SPEED), 0);
      on_sw = 1'b1; tick();
      speed = 8'd30; pulse_set();
      check("low_set_ignored", int'(ACTIVE), 0);
      pulse_resume();
      check("resume_no_valid", int'(ACTIVE), 0);

      speed = 8'd60; pulse_set();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("rst_mid_engaged", int'(ACTIVE), 0);

      for (int c = 0; c < 5000; c++) begin
         rst_n = ($urandom_range(0, 599) != 0);
         on_sw = ($urandom_range(0, 249) != 0);
         set_btn = ($urandom_range(0, 24) == 0);
         resume_btn = ($urandom_range(0, 24) == 0);
         brake = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 19) == 0) accel = ~accel;
         if ($urandom_range(0, 11) == 0) speed = 8'($urandom_range(25, 100));
         inj = ($urandom_range(0, 79) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/cruise_regulator.md
Name: cruise_regulator

Overview:
- Downstream consumer of the cascaded bit-slice magnitude comparator chain, which compares measured speed against the held set-point and produces L/EQ/G.
- Owns the cruise-control mode state machine and the set-point register that feeds the comparator's B operand.
- Issues debounced throttle-up / throttle-down commands to the actuator stage.

Parameters:
- SPEED_W, 8: width of the speed and set-point buses.
- MIN_SPEED, 40: lowest speed at which set is accepted.
- HOLD_CYC, 3: consecutive cycles a compare result must persist before a throttle command asserts (1..15).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- on_sw  input  1  cruise master switch, level
- set_btn  input  1  set button, level (rising edge acts)
- resume_btn  input  1  resume button, level (rising edge acts)
- brake  input  1  brake pedal, level
- accel  input  1  driver accelerator pedal, level
- speed  input  SPEED_W  measured speed, unsigned
- L  input  1  comparator: speed < SET_SPEED
- EQ  input  1  comparator: speed == SET_SPEED
- G  input  1  comparator: speed > SET_SPEED
- SET_SPEED  output  SPEED_W  held set-point, drives comparator B
- ACTIVE  output  1  high in ENGAGED only
- THR_UP  output  1  throttle increase command
- THR_DN  output  1  throttle decrease command
- CMP_ERR  output  1  sticky: L/EQ/G not one-hot while ENGAGED

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State OFF.
  - SET_SPEED=0, set-valid flag=0.
  - ACTIVE=0, THR_UP=0, THR_DN=0, CMP_ERR=0.
  - Filter counter=0.
  - Button edge registers=0.
  - Reset mid-ENGAGED drops all outputs on that edge.
- Buttons: one register per button; edge = btn & ~btn_q. Holding a button acts once.
- States: OFF, STANDBY, ENGAGED, OVERRIDE. Transition priority, highest first:
  1. on_sw=0: any state -> OFF. SET_SPEED and valid flag cleared.
  2. OFF and on_sw=1 -> STANDBY.
  3. brake=1 in ENGAGED or OVERRIDE -> STANDBY. SET_SPEED retained.
  4. STANDBY:
     - set edge with speed >= MIN_SPEED and brake=0: SET_SPEED <= speed, valid <= 1, -> ENGAGED.
     - set edge with speed < MIN_SPEED: ignored.
     - resume edge with valid=1 and brake=0: -> ENGAGED with SET_SPEED unchanged.
     - resume edge with valid=0: ignored.
  5. ENGAGED:
     - accel=1 -> OVERRIDE.
     - set edge (speed >= MIN_SPEED): re-captures SET_SPEED, stays ENGAGED.
  6. OVERRIDE: accel=0 -> ENGAGED. Set edge while in OVERRIDE re-captures SET_SPEED (speed >= MIN_SPEED), stays OVERRIDE.
- Simultaneous events: brake and set edge in STANDBY -> set ignored. brake and accel in ENGAGED -> STANDBY.
- Comparator inputs are sampled directly each cycle (combinational from SET_SPEED); they are valid the cycle after SET_SPEED changes. The filter counter is cleared on any SET_SPEED write.
- Filter:
  - Tracks last sampled class (L or G).
  - Counter increments while the same class persists; saturates at HOLD_CYC.
  - Cleared on class change, on EQ, and outside ENGAGED.
- Commands (registered):
  - THR_UP=1 when ENGAGED, class L and counter==HOLD_CYC. First assertion is HOLD_CYC+1 edges after L first sampled.
  - THR_DN is the same for G.
  - Never both high. Both drop the edge after EQ, a class change, or leaving ENGAGED.
- Compare fault: if L+EQ+G != 1 while ENGAGED:
  - CMP_ERR is set (sticky until reset or OFF).
  - The filter is cleared for that cycle; no command issues.
  - State unaffected.
- ACTIVE is registered and equals (state==ENGAGED).

Test Plan:
- Reset then on_sw=1, speed=60, one-cycle set pulse -> STANDBY then ENGAGED; SET_SPEED=60, ACTIVE=1, THR_UP=THR_DN=0 while EQ.
- Engaged at 60, drive L=1 steady -> THR_UP rises exactly 4 edges after L first sampled (HOLD_CYC=3). Then EQ=1 -> THR_UP=0 next edge.
- speed=30, set pulse in STANDBY -> stays STANDBY, SET_SPEED=0. Resume pulse -> ignored.
- Engaged at 60, brake=1 -> STANDBY, ACTIVE=0, SET_SPEED=60. Release brake, resume pulse -> ENGAGED at 60. on_sw=0 -> OFF, SET_SPEED=0.
- Engaged, accel=1 with G=1 -> OVERRIDE, THR_DN stays 0. accel=0 -> ENGAGED, THR_DN after HOLD_CYC+1 edges.
- Engaged, force L=G=1 -> CMP_ERR=1 and stays high, no THR_UP/THR_DN. rst_n=0 mid-ENGAGED -> all outputs 0 next edge.
